// File: rtl/uart_apb_host.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_host
// Brief    : APB initiator that configures a UART register block, then polls
//            its flag register to move bytes between a host byte stream and
//            the UART data register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_host #(
    parameter logic [15:0] BAUD_DIVINT  = 16'd27,
    parameter logic [5:0]  BAUD_DIVFRAC = 6'd8,
    parameter logic [15:0] LCR_H_VAL    = 16'h0070,
    parameter logic [15:0] CR_VAL       = 16'h0301
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [11:0] PADDR,
    output logic [15:0] PWDATA,
    input  logic [15:0] PRDATA,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic [3:0]  rx_err,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done
);

    localparam logic [3:0] c_idle        = 4'd0;
    localparam logic [3:0] c_init_setup  = 4'd1;
    localparam logic [3:0] c_init_access = 4'd2;
    localparam logic [3:0] c_poll_setup  = 4'd3;
    localparam logic [3:0] c_poll_access = 4'd4;
    localparam logic [3:0] c_rd_setup    = 4'd5;
    localparam logic [3:0] c_rd_access   = 4'd6;
    localparam logic [3:0] c_wr_setup    = 4'd7;
    localparam logic [3:0] c_wr_access   = 4'd8;

    localparam logic [11:0] c_addr_dr    = 12'h000;
    localparam logic [11:0] c_addr_fr    = 12'h018;
    localparam logic [11:0] c_addr_ibrd  = 12'h024;
    localparam logic [11:0] c_addr_fbrd  = 12'h028;
    localparam logic [11:0] c_addr_lcr_h = 12'h02C;
    localparam logic [11:0] c_addr_cr    = 12'h030;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [1:0]  r_init_idx;
    logic [1:0]  w_init_idx_nxt;
    logic        r_init_done;
    logic        w_init_done_nxt;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        w_hold_full_nxt;
    logic        r_tx_ready;
    logic        w_tx_accept;
    logic [7:0]  r_rx_data;
    logic [3:0]  r_rx_err;
    logic        r_rx_valid;
    logic        w_rxfe;
    logic        w_txff;
    logic        w_rx_room;

    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [11:0] r_paddr;
    logic [15:0] r_pwdata;
    logic        w_psel_nxt;
    logic        w_penable_nxt;
    logic        w_pwrite_nxt;
    logic [11:0] w_paddr_nxt;
    logic [15:0] w_pwdata_nxt;
    logic [11:0] w_init_addr;
    logic [15:0] w_init_data;
    logic        w_unused_prdata;

    assign w_rxfe          = PRDATA[4];
    assign w_txff          = PRDATA[5];
    assign w_rx_room       = !r_rx_valid || rx_ready;
    assign w_tx_accept     = tx_valid && r_tx_ready;
    assign w_unused_prdata = &{1'b0, PRDATA[15:12], PRDATA[3:0]};

    // The index advances on every INIT ACCESS, so the following SETUP
    // must already present the next register of the sequence.
    assign w_init_idx_nxt  = (r_state == c_init_access) ? r_init_idx + 2'd1 : r_init_idx;
    assign w_init_done_nxt = r_init_done || ((r_state == c_init_access) && (r_init_idx == 2'd3));

    always_comb begin
        w_hold_full_nxt = r_hold_full;
        if (w_tx_accept) begin
            w_hold_full_nxt = 1'b1;
        end else if (r_state == c_wr_access) begin
            w_hold_full_nxt = 1'b0;
        end
    end

    always_comb begin
        w_init_addr = c_addr_ibrd;
        w_init_data = BAUD_DIVINT;
        case (w_init_idx_nxt)
            2'd1: begin
                w_init_addr = c_addr_fbrd;
                w_init_data = {10'd0, BAUD_DIVFRAC};
            end
            2'd2: begin
                w_init_addr = c_addr_lcr_h;
                w_init_data = LCR_H_VAL;
            end
            2'd3: begin
                w_init_addr = c_addr_cr;
                w_init_data = CR_VAL;
            end
            default: begin
                w_init_addr = c_addr_ibrd;
                w_init_data = BAUD_DIVINT;
            end
        endcase
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; receive has priority so the UART RX FIFO never overruns
    always_comb begin
        w_next_state = c_idle;
        case (r_state)
            c_idle:        w_next_state = c_init_setup;
            c_init_setup:  w_next_state = c_init_access;
            c_init_access: w_next_state = (r_init_idx == 2'd3) ? c_poll_setup : c_init_setup;
            c_poll_setup:  w_next_state = c_poll_access;
            c_poll_access: begin
                if (!w_rxfe && w_rx_room) begin
                    w_next_state = c_rd_setup;
                end else if (!w_txff && r_hold_full) begin
                    w_next_state = c_wr_setup;
                end else begin
                    w_next_state = c_poll_setup;
                end
            end
            c_rd_setup:    w_next_state = c_rd_access;
            c_rd_access:   w_next_state = c_poll_setup;
            c_wr_setup:    w_next_state = c_wr_access;
            c_wr_access:   w_next_state = c_poll_setup;
            default:       w_next_state = c_idle;
        endcase
    end

    // Output logic: APB bus values for the upcoming cycle, registered below
    always_comb begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = 1'b0;
        w_paddr_nxt   = 12'h000;
        w_pwdata_nxt  = 16'h0000;
        case (w_next_state)
            c_init_setup, c_init_access: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_next_state == c_init_access);
                w_pwrite_nxt  = 1'b1;
                w_paddr_nxt   = w_init_addr;
                w_pwdata_nxt  = w_init_data;
            end
            c_poll_setup, c_poll_access: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_next_state == c_poll_access);
                w_paddr_nxt   = c_addr_fr;
            end
            c_rd_setup, c_rd_access: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_next_state == c_rd_access);
                w_paddr_nxt   = c_addr_dr;
            end
            c_wr_setup, c_wr_access: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_next_state == c_wr_access);
                w_pwrite_nxt  = 1'b1;
                w_paddr_nxt   = c_addr_dr;
                w_pwdata_nxt  = {8'h00, r_hold};
            end
            default: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 12'h000;
            r_pwdata  <= 16'h0000;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_tx_ready  <= 1'b0;
        end else begin
            r_init_idx  <= w_init_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_tx_ready  <= w_init_done_nxt && !w_hold_full_nxt;
            if (w_tx_accept) begin
                r_hold <= tx_data;
            end
        end
    end

    // A completing RD overrides a same-cycle consumer handshake
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_data  <= 8'h00;
            r_rx_err   <= 4'h0;
            r_rx_valid <= 1'b0;
        end else if (r_state == c_rd_access) begin
            r_rx_data  <= PRDATA[7:0];
            r_rx_err   <= PRDATA[11:8];
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_err    = r_rx_err;
    assign rx_valid  = r_rx_valid;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_host
// Brief    : Directed self-checking bench for uart_apb_host with a simple
//            UART register slave model and an APB transfer monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_host;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic [3:0]  rx_err;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done;

    logic [15:0] fr_val = 16'h0090;
    logic [15:0] dr_val = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    int          cyc = 0;
    int          proto_err = 0;
    int          poll_cnt = 0;
    int          rd_cnt = 0;
    logic        prev_setup = 1'b0;
    logic [11:0] prev_addr = 12'h000;
    logic        prev_wr = 1'b0;
    logic [15:0] prev_wd = 16'h0000;
    logic [11:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          ev[$];
    int          acc_cyc = 0;

    uart_apb_host dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .init_done(init_done)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA = (PSEL && PENABLE && PADDR == 12'h018) ? fr_val :
                    (PSEL && PENABLE && PADDR == 12'h000) ? dr_val : 16'h0000;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prev_setup = 1'b0;
        end else begin
            cyc++;
            if (PSEL && PENABLE) begin
                if (!prev_setup || PADDR != prev_addr || PWRITE != prev_wr ||
                    (PWRITE && PWDATA != prev_wd))
                    proto_err++;
                if (PWRITE) begin
                    wr_addr.push_back(PADDR);
                    wr_data.push_back(PWDATA);
                    wr_cyc.push_back(cyc);
                end else if (PADDR == 12'h018) begin
                    poll_cnt++;
                end else if (PADDR == 12'h000) begin
                    rd_cnt++;
                end
                if (PADDR == 12'h000) ev.push_back(PWRITE ? 1 : 0);
            end else if (prev_setup) begin
                proto_err++;
            end
            if (!PSEL && PENABLE) proto_err++;
            prev_setup = PSEL && !PENABLE;
            prev_addr  = PADDR;
            prev_wr    = PWRITE;
            prev_wd    = PWDATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 30) begin
            tick();
            k++;
        end
        chk("tx_accept_ready", {31'd0, tx_ready}, 32'd1);
        tick();
        acc_cyc  = cyc;
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic wait_wr(input int n0, input int bound, output int seen);
        int k;
        k = 0;
        while (wr_addr.size() <= n0 && k < bound) begin
            tick();
            k++;
        end
        seen = (wr_addr.size() > n0) ? 1 : 0;
    endtask

    initial begin
        int mark, mark_rd, seen, k, bad, e0, e1;

        // Reset state
        repeat (3) tick();
        chk("rst_psel", {31'd0, PSEL}, 0);
        chk("rst_penable", {31'd0, PENABLE}, 0);
        chk("rst_pwrite", {31'd0, PWRITE}, 0);
        chk("rst_paddr", {20'd0, PADDR}, 0);
        chk("rst_pwdata", {16'd0, PWDATA}, 0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_rx_err", {28'd0, rx_err}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);

        // Init sequence
        PRESETn = 1'b1;
        tick();
        chk("init_first_setup_psel", {31'd0, PSEL}, 1);
        chk("init_first_setup_addr", {20'd0, PADDR}, 32'h024);
        repeat (7) tick();
        chk("init_cr_access_addr", {20'd0, PADDR}, 32'h030);
        chk("init_cr_access_en", {31'd0, PENABLE}, 1);
        chk("init_done_during_cr", {31'd0, init_done}, 0);
        tick();
        chk("init_done_after_cr", {31'd0, init_done}, 1);
        chk("poll_first_addr", {20'd0, PADDR}, 32'h018);
        chk("poll_first_pwrite", {31'd0, PWRITE}, 0);
        chk("init_wr_count", wr_addr.size(), 4);
        if (wr_addr.size() >= 4) begin
            chk("init_w0_addr", {20'd0, wr_addr[0]}, 32'h024);
            chk("init_w0_data", {16'd0, wr_data[0]}, 32'd27);
            chk("init_w1_addr", {20'd0, wr_addr[1]}, 32'h028);
            chk("init_w1_data", {16'd0, wr_data[1]}, 32'd8);
            chk("init_w2_addr", {20'd0, wr_addr[2]}, 32'h02C);
            chk("init_w2_data", {16'd0, wr_data[2]}, 32'h0070);
            chk("init_w3_addr", {20'd0, wr_addr[3]}, 32'h030);
            chk("init_w3_data", {16'd0, wr_data[3]}, 32'h0301);
            chk("init_spacing_1", wr_cyc[1] - wr_cyc[0], 2);
            chk("init_spacing_2", wr_cyc[2] - wr_cyc[1], 2);
            chk("init_spacing_3", wr_cyc[3] - wr_cyc[2], 2);
        end

        // TX path
        repeat (3) tick();
        mark = wr_addr.size();
        send_byte(8'hA5);
        bad = 0;
        k = 0;
        while (wr_addr.size() <= mark && k < 12) begin
            if (tx_ready) bad++;
            tick();
            k++;
        end
        chk("tx_wr_seen", (wr_addr.size() > mark) ? 1 : 0, 1);
        chk("tx_ready_low_while_held", bad, 0);
        chk("tx_ready_after_wr_access", {31'd0, tx_ready}, 1);
        if (wr_addr.size() > mark) begin
            chk("tx_wr_addr", {20'd0, wr_addr[mark]}, 32'h000);
            chk("tx_wr_data", {16'd0, wr_data[mark]}, 32'h00A5);
            chk("tx_latency_le6", (wr_cyc[mark] - acc_cyc <= 6) ? 1 : 0, 1);
        end

        // TX backpressure
        fr_val = 16'h00B0;
        tick();
        mark = wr_addr.size();
        send_byte(8'h3C);
        k = poll_cnt;
        seen = 0;
        while (poll_cnt < k + 5 && seen < 40) begin
            tick();
            seen++;
        end
        chk("bp_polls_done", (poll_cnt >= k + 5) ? 1 : 0, 1);
        chk("bp_no_wr_while_full", wr_addr.size(), mark);
        fr_val = 16'h0090;
        wait_wr(mark, 10, seen);
        chk("bp_wr_seen", seen, 1);
        if (seen != 0) chk("bp_wr_data", {16'd0, wr_data[mark]}, 32'h003C);
        repeat (10) tick();
        chk("bp_wr_once", wr_addr.size(), mark + 1);

        // RX path with consumer stalled
        rx_ready = 1'b0;
        dr_val   = 16'h0342;
        mark_rd  = rd_cnt;
        fr_val   = 16'h0000;
        k = 0;
        while (!rx_valid && k < 10) begin
            tick();
            k++;
        end
        chk("rx_valid_set", {31'd0, rx_valid}, 1);
        chk("rx_data", {24'd0, rx_data}, 32'h42);
        chk("rx_err", {28'd0, rx_err}, 32'h3);
        dr_val = 16'h0155;
        repeat (10) tick();
        chk("rx_valid_held", {31'd0, rx_valid}, 1);
        chk("rx_data_held", {24'd0, rx_data}, 32'h42);
        chk("rx_single_rd", rd_cnt - mark_rd, 1);
        fr_val   = 16'h0090;
        tick();
        rx_ready = 1'b1;
        tick();
        chk("rx_valid_cleared", {31'd0, rx_valid}, 0);

        // Priority: RD before WR
        fr_val = 16'h00B0;
        tick();
        send_byte(8'h5A);
        repeat (4) tick();
        mark    = ev.size();
        mark_rd = rd_cnt;
        dr_val  = 16'h0077;
        fr_val  = 16'h0000;
        k = 0;
        while (rd_cnt == mark_rd && k < 10) begin
            tick();
            k++;
        end
        fr_val = 16'h0090;
        k = 0;
        while (ev.size() < mark + 2 && k < 12) begin
            tick();
            k++;
        end
        e0 = (ev.size() > mark) ? ev[mark] : 9;
        e1 = (ev.size() > mark + 1) ? ev[mark + 1] : 9;
        chk("prio_first_is_rd", e0, 0);
        chk("prio_second_is_wr", e1, 1);
        chk("prio_rx_data", {24'd0, rx_data}, 32'h77);
        if (wr_data.size() > 0) chk("prio_wr_data", {16'd0, wr_data[wr_data.size() - 1]}, 32'h005A);

        // Mid-operation reset during WR ACCESS
        fr_val = 16'h00B0;
        tick();
        send_byte(8'h99);
        fr_val = 16'h0090;
        k = 0;
        while (!(PSEL && PENABLE && PWRITE && PADDR == 12'h000) && k < 12) begin
            tick();
            k++;
        end
        chk("mr_in_wr_access", (PSEL && PENABLE && PWRITE && PADDR == 12'h000) ? 1 : 0, 1);
        mark = wr_addr.size();
        #2 PRESETn = 1'b0;
        #1;
        chk("mr_psel_drop", {31'd0, PSEL}, 0);
        chk("mr_penable_drop", {31'd0, PENABLE}, 0);
        chk("mr_tx_ready", {31'd0, tx_ready}, 0);
        chk("mr_init_done", {31'd0, init_done}, 0);
        repeat (2) tick();
        PRESETn = 1'b1;
        tick();
        chk("mr_restart_addr", {20'd0, PADDR}, 32'h024);
        repeat (20) tick();
        chk("mr_init_wr_count", wr_addr.size(), mark + 4);
        if (wr_addr.size() > mark) chk("mr_restart_first_data", {16'd0, wr_data[mark]}, 32'd27);
        chk("mr_held_byte_dropped_ready", {31'd0, tx_ready}, 1);
        chk("mr_init_done_again", {31'd0, init_done}, 1);

        chk("apb_protocol_errors", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_apb_host.md
# uart_apb_host

APB initiator that drives the UART register block from a simple byte-stream client. After reset it programs the baud divisors, line control and control registers. It then polls the flag register forever. Bytes from the client go into the UART data register when the transmit FIFO has room, and bytes are read out of the data register when the receive FIFO is non-empty. It sits between a host-side byte producer/consumer and the UART's `PSEL`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA`/`PRDATA` port.

## Interface
- `BAUD_DIVINT`, 16'd27, value written to UARTIBRD (0x024)
- `BAUD_DIVFRAC`, 6'd8, value written to UARTFBRD (0x028), zero-extended to 16 bits
- `LCR_H_VAL`, 16'h0070, value written to UARTLCR_H (0x02C): 8-bit words, FIFO enabled
- `CR_VAL`, 16'h0301, value written to UARTCR (0x030): RXE, TXE, UARTEN

Ports:
- `PCLK` in 1: sole clock; all state changes on rising edge
- `PRESETn` in 1: asynchronous, active-low reset
- `PSEL` out 1: APB select
- `PENABLE` out 1: APB access phase
- `PWRITE` out 1: 1 = write
- `PADDR` out 12: register byte address
- `PWDATA` out 16: write data
- `PRDATA` in 16: read data, sampled at the end of the access phase
- `tx_data` in 8: byte to transmit
- `tx_valid` in 1: `tx_data` valid
- `tx_ready` out 1: holding register free; a byte is accepted when `tx_valid && tx_ready`
- `rx_data` out 8: received byte
- `rx_err` out 4: {OE, BE, PE, FE}, taken from DR bits [11:8] of the same read
- `rx_valid` out 1: `rx_data`/`rx_err` valid; held until `rx_valid && rx_ready`
- `rx_ready` in 1: consumer accepts
- `init_done` out 1: configuration complete; sticky until reset

## Operation
- **Reset values:** `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0, `tx_ready`=0, `rx_data`=0, `rx_err`=0, `rx_valid`=0, `init_done`=0.
- All APB outputs are registered.
- **Transfer shape:** every transfer is a SETUP cycle (`PSEL`=1, `PENABLE`=0) followed by one ACCESS cycle (`PSEL`=1, `PENABLE`=1).
  - There are no wait states; the slave has no PREADY.
  - `PADDR`, `PWRITE` and `PWDATA` are stable across both cycles.
  - ACCESS may go directly to the next SETUP.
  - In IDLE, `PSEL`=`PENABLE`=0.
- **States:** INIT, POLL, RD, WR, each split into SETUP/ACCESS. A 2-bit `init_idx` counter drives INIT.
- **INIT:** issues four writes in this order: IBRD, FBRD, LCR_H, CR.
  - `init_idx` increments on each ACCESS.
  - After the CR ACCESS, `init_done`←1 and the next state is POLL_SETUP.
- **POLL:** reads UARTFR (0x018). At the end of ACCESS, RXFE = `PRDATA`[4] and TXFF = `PRDATA`[5] are used for the decision.
- **Decision after POLL_ACCESS, in priority order:**
  - RXFE==0 and output buffer free (`!rx_valid || rx_ready` in that cycle) → RD.
  - Otherwise TXFF==0 and the holding register is full → WR.
  - Otherwise → POLL.
- **RD:** reads UARTDR (0x000). At the end of ACCESS: `rx_data`←`PRDATA`[7:0], `rx_err`←`PRDATA`[11:8], `rx_valid`←1. Next state is POLL.
- **WR:** writes UARTDR with {8'h00, held byte}. At the end of ACCESS the holding register empties. Next state is POLL.
- **TX holding register:** one byte. `tx_ready` = `init_done && !hold_full`, and is registered.
  - A byte can be captured during any state.
  - `tx_ready` returns to 1 in the cycle after WR_ACCESS.
- **RX output register:** `rx_valid` clears on `rx_valid && rx_ready`.
  - If an RD completes in the same cycle as that handshake, the new byte wins and `rx_valid` stays 1.
- **Reset mid-operation:** all state returns to reset values asynchronously. Any in-flight transfer is abandoned and INIT restarts from IBRD.

## Timing
- Reset release to first SETUP: 1 cycle (the first rising edge after deassertion enters INIT_SETUP).
- INIT occupies 8 cycles. `init_done` is 1 from the cycle after the CR ACCESS.
- A poll loop iteration is 2 cycles; a poll followed by an action is 4 cycles.
- RX latency: from POLL_SETUP with data present to `rx_valid`=1 is 4 cycles (POLL S/A, RD S/A, then registered).
- TX latency: a byte accepted while IDLE in POLL reaches the UARTDR write ACCESS no later than 2 + 2 + 2 cycles (current poll, next poll, WR).
- With RX constantly available and the consumer ready, TX is starved. This is accepted: receive overrun has priority.

## Test plan
- **Reset/init:** release `PRESETn`; expect writes, in order, of 0x024←27, 0x028←8, 0x02C←0x0070, 0x030←0x0301.
  - Each write is exactly 2 cycles.
  - `init_done` rises 1 cycle after the last ACCESS.
  - All outputs are at reset values beforehand.
- **TX path:** send `tx_data`=0xA5. Return FR=0x0090 (RXFE, TXFE) on poll. Expect a write of 0x000←0x00A5.
  - `tx_ready` is 0 from acceptance until the cycle after that ACCESS.
- **TX backpressure:** FR=0x00B0 (TXFF set) for 5 polls → no WR. Then FR=0x0090 → WR of the held byte, exactly once.
- **RX path:** FR=0x0000, DR read returns 0x0342.
  - Expect `rx_data`=0x42 and `rx_err`=4'b0011.
  - `rx_valid` is held while `rx_ready`=0, and no further RD is issued while the buffer is full.
- **Priority:** `tx_valid` pending and FR=0x0000 → RD before WR. With `rx_ready`=1 throughout, the next poll with RXFE=1 issues WR.
- **Mid-operation reset:** assert `PRESETn` during WR_ACCESS.
  - `PSEL` drops immediately, `tx_ready`=0 and `init_done`=0.
  - After release, INIT restarts at 0x024 and the held byte is discarded.
